// File: rtl/wake_ctl_pkg.sv
// -----------------------------------------------------------------------------
// wake_ctl_pkg
// Shared definitions for the wake controller (last stage of the keyword-
// spotting pipeline).
//   - state_t      : FSM state encoding, also exported on wake_ctl.state_o
//   - *_BW_DEF     : default widths for the hit threshold, cooldown timer
//                    and wake event counter
// -----------------------------------------------------------------------------
package wake_ctl_pkg;

   localparam int HIT_BW_DEF  = 4;
   localparam int COOL_BW_DEF = 24;
   localparam int CNT_BW_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LISTEN   = 2'd1,
      ST_WAKE     = 2'd2,
      ST_COOLDOWN = 2'd3
   } state_t;

endpackage

// File: rtl/wake_ctl_timer.sv
// -----------------------------------------------------------------------------
// wake_ctl_timer
// Loadable down-counter that times the post-acknowledge cooldown.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   clear    in  force the count to 0 (highest priority)
//   load     in  load load_val into the counter
//   load_val in  COOL_BW  value to load
//   done     out high in the cycle the count steps from 1 to 0
// The counter decrements every cycle while non-zero and rests at 0.
// -----------------------------------------------------------------------------
module wake_ctl_timer #(
   parameter int COOL_BW = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               load,
   input  logic [COOL_BW-1:0] load_val,
   output logic               done
);

   logic [COOL_BW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - COOL_BW'(1);
      end
   end

   // A count of 1 means the next edge is the 1->0 step, so the FSM can leave
   // COOLDOWN on that same edge and the cooldown lasts exactly load_val cycles.
   assign done = (cnt == COOL_BW'(1)) && !clear && !load;

endmodule

// File: rtl/wake_ctl.sv
// -----------------------------------------------------------------------------
// wake_ctl
// Qualifies word-detector results (N consecutive positives), raises a sticky
// wake line to the host, holds it until acknowledged, then waits out a
// programmable cooldown before listening again.
//
// Ports:
//   clk_i              in  system clock
//   rst_n_i            in  asynchronous active-low reset
//   ctl_pipeline_en_i  in  pipeline enable; low forces IDLE (top priority)
//   wrd_wake_i         in  detector result (1 = keyword)
//   wrd_wake_valid_i   in  result strobe, one cycle per inference
//   ack_i              in  host acknowledge; clears wake (used only in WAKE)
//   cfg_hits_i         in  HIT_BW  consecutive positives required, 0 acts as 1
//   cfg_cooldown_i     in  COOL_BW cooldown length in cycles
//   wake_o             out sticky wake level
//   wake_pulse_o       out one-cycle pulse on wake_o rising
//   state_o            out current FSM state (state_t encoding)
//   wake_count_o       out CNT_BW saturating wake event count
//
// Handshake: a result is consumed only in a cycle where wrd_wake_valid_i=1;
// there is no back-pressure. wake_o is a level that stays high until the
// host samples ack_i=1 while in WAKE; ack_i in any other state has no effect.
//
// Configuration macro WAKE_CTL_STATS_EN: when defined, wake_count_o counts
// wake pulses and saturates; otherwise it is tied to 0 with no counter flops.
// All outputs are registered.
// -----------------------------------------------------------------------------
module wake_ctl
   import wake_ctl_pkg::*;
#(
   parameter int HIT_BW  = HIT_BW_DEF,
   parameter int COOL_BW = COOL_BW_DEF,
   parameter int CNT_BW  = CNT_BW_DEF
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               ctl_pipeline_en_i,
   input  logic               wrd_wake_i,
   input  logic               wrd_wake_valid_i,
   input  logic               ack_i,
   input  logic [HIT_BW-1:0]  cfg_hits_i,
   input  logic [COOL_BW-1:0] cfg_cooldown_i,
   output logic               wake_o,
   output logic               wake_pulse_o,
   output logic [1:0]         state_o,
   output logic [CNT_BW-1:0]  wake_count_o
);

   state_t            state_q, state_d;
   logic [HIT_BW-1:0] hit_q, hit_d;
   logic [HIT_BW:0]   hit_inc;   // one bit wider so the compare never wraps
   logic [HIT_BW:0]   hit_need;
   logic              tmr_load, tmr_clear, tmr_done;
   logic              wake_d, pulse_d;

   wake_ctl_timer #(.COOL_BW(COOL_BW)) u_timer (
      .clk      (clk_i),
      .rst_n    (rst_n_i),
      .clear    (tmr_clear),
      .load     (tmr_load),
      .load_val (cfg_cooldown_i),
      .done     (tmr_done)
   );

   always_comb begin
      hit_inc  = {1'b0, hit_q} + (HIT_BW+1)'(1);
      hit_need = (cfg_hits_i == '0) ? (HIT_BW+1)'(1) : {1'b0, cfg_hits_i};
   end

   always_comb begin
      state_d   = state_q;
      hit_d     = hit_q;
      tmr_load  = 1'b0;
      tmr_clear = 1'b0;
      if (!ctl_pipeline_en_i) begin
         state_d   = ST_IDLE;
         hit_d     = '0;
         tmr_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               hit_d   = '0;
               state_d = ST_LISTEN;
            end
            ST_LISTEN: begin
               if (wrd_wake_valid_i) begin
                  if (wrd_wake_i) begin
                     if (hit_inc >= hit_need) begin
                        state_d = ST_WAKE;
                        hit_d   = '0;
                     end else if (hit_q != '1) begin
                        hit_d = hit_inc[HIT_BW-1:0];
                     end
                  end else begin
                     hit_d = '0;
                  end
               end
            end
            ST_WAKE: begin
               if (ack_i) begin
                  tmr_load = 1'b1;
                  state_d  = (cfg_cooldown_i == '0) ? ST_LISTEN : ST_COOLDOWN;
               end
            end
            ST_COOLDOWN: begin
               if (tmr_done) state_d = ST_LISTEN;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      // Outputs are derived from the next state so they register alongside it.
      wake_d  = (state_d == ST_WAKE);
      pulse_d = wake_d && (state_q != ST_WAKE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         hit_q        <= '0;
         wake_o       <= 1'b0;
         wake_pulse_o <= 1'b0;
      end else begin
         state_q      <= state_d;
         hit_q        <= hit_d;
         wake_o       <= wake_d;
         wake_pulse_o <= pulse_d;
      end
   end

   assign state_o = state_q;

`ifdef WAKE_CTL_STATS_EN
   logic [CNT_BW-1:0] cnt_q;

   // Counts registered pulses; only reset clears it, enable drops keep it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (wake_pulse_o && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_BW'(1);
      end
   end

   assign wake_count_o = cnt_q;
`else
   assign wake_count_o = '0;
`endif

endmodule

// File: tb/tb_wake_ctl.sv
// -----------------------------------------------------------------------------
// tb_wake_ctl
// Self-checking bench for wake_ctl. Each scenario queues rows of
// {enable, valid, wake, ack, expected state, expected wake, expected pulse};
// the driver applies a row and pushes its expected outputs (plus the expected
// wake count) onto exp_q, and the scenario pops and compares one cycle later.
// Built with CNT_BW=2 so counter saturation is reachable when
// WAKE_CTL_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_wake_ctl;

   localparam int HIT_BW  = 4;
   localparam int COOL_BW = 24;
   localparam int CNT_BW  = 2;
   localparam int CNT_MAX = (1 << CNT_BW) - 1;

   logic               clk_i = 1'b0;
   logic               rst_n_i = 1'b0;
   logic               ctl_pipeline_en_i = 1'b0;
   logic               wrd_wake_i = 1'b0;
   logic               wrd_wake_valid_i = 1'b0;
   logic               ack_i = 1'b0;
   logic [HIT_BW-1:0]  cfg_hits_i = '0;
   logic [COOL_BW-1:0] cfg_cooldown_i = '0;
   logic               wake_o;
   logic               wake_pulse_o;
   logic [1:0]         state_o;
   logic [CNT_BW-1:0]  wake_count_o;

   wake_ctl #(.HIT_BW(HIT_BW), .COOL_BW(COOL_BW), .CNT_BW(CNT_BW)) dut (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .ctl_pipeline_en_i (ctl_pipeline_en_i),
      .wrd_wake_i        (wrd_wake_i),
      .wrd_wake_valid_i  (wrd_wake_valid_i),
      .ack_i             (ack_i),
      .cfg_hits_i        (cfg_hits_i),
      .cfg_cooldown_i    (cfg_cooldown_i),
      .wake_o            (wake_o),
      .wake_pulse_o      (wake_pulse_o),
      .state_o           (state_o),
      .wake_count_o      (wake_count_o)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- scoreboard state ----------------
   int               checks = 0;
   int               failures = 0;
   logic [7:0]       stim_q[$];
   logic [CNT_BW+3:0] exp_q[$];   // {state, wake, pulse, count}
   int               exp_cnt = 0;
   logic             prev_pulse = 1'b0;

   // ---------------- driver tasks ----------------
   task automatic plan(input logic en, input logic v, input logic w, input logic a,
                       input logic [1:0] st, input logic wk, input logic pl);
      stim_q.push_back({en, v, w, a, st, wk, pl});
   endtask

   // Applies the next row and records what the outputs must be after the edge.
   task automatic drive_next();
      logic [7:0]        e;
      logic [CNT_BW-1:0] c;
      e = stim_q.pop_front();
      {ctl_pipeline_en_i, wrd_wake_valid_i, wrd_wake_i, ack_i} = e[7:4];
      if (prev_pulse && exp_cnt < CNT_MAX) exp_cnt++;
      prev_pulse = e[0];
`ifdef WAKE_CTL_STATS_EN
      c = CNT_BW'(exp_cnt);
`else
      c = '0;
`endif
      exp_q.push_back({e[3:0], c});
   endtask

   task automatic model_reset();
      exp_cnt    = 0;
      prev_pulse = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [CNT_BW+3:0] got;
      logic [CNT_BW+3:0] exp;
      int n = 0;
      rst_n_i = 1'b0;
      #1;
      got = {state_o, wake_o, wake_pulse_o, wake_count_o};
      checks++;
      if (got !== '0) begin
         failures++;
         $display("FAIL reset_initial: got st/wk/pl/cnt=%b required %b", got, {(CNT_BW+4){1'b0}});
      end
      @(posedge clk_i); #1;
      got = {state_o, wake_o, wake_pulse_o, wake_count_o};
      checks++;
      if (got !== '0) begin
         failures++;
         $display("FAIL reset_held: got st/wk/pl/cnt=%b required %b", got, {(CNT_BW+4){1'b0}});
      end
      rst_n_i = 1'b1;
      model_reset();
      plan(0,0,0,0, 2'd0,0,0);
      plan(0,1,1,0, 2'd0,0,0);
      while (stim_q.size() > 0) begin
         drive_next();
         @(posedge clk_i); #1;
         exp = exp_q.pop_front();
         got = {state_o, wake_o, wake_pulse_o, wake_count_o};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset_idle step %0d: got st/wk/pl/cnt=%b required %b", n, got, exp);
         end
         n++;
      end
   endtask

   task automatic test_threshold();
      logic [CNT_BW+3:0] got, exp;
      int n = 0;
      int pulses = 0;
      cfg_hits_i     = 4'd3;
      cfg_cooldown_i = '0;
      plan(1,0,0,0, 2'd1,0,0);   // IDLE -> LISTEN
      plan(1,1,1,0, 2'd1,0,0);   // hit 1
      plan(1,1,1,0, 2'd1,0,0);   // hit 2
      plan(1,1,0,0, 2'd1,0,0);   // negative clears
      plan(1,1,1,0, 2'd1,0,0);   // hit 1
      plan(1,0,0,0, 2'd1,0,0);   // no valid: count kept
      plan(1,1,1,0, 2'd1,0,0);   // hit 2
      plan(1,1,1,0, 2'd2,1,1);   // hit 3 -> wake + pulse
      plan(1,0,0,0, 2'd2,1,0);   // sticky, pulse gone
      plan(1,1,1,0, 2'd2,1,0);   // valids ignored in WAKE
      plan(1,0,0,1, 2'd1,0,0);   // ack, cooldown 0 -> LISTEN
      while (stim_q.size() > 0) begin
         drive_next();
         @(posedge clk_i); #1;
         exp = exp_q.pop_front();
         got = {state_o, wake_o, wake_pulse_o, wake_count_o};
         if (wake_pulse_o === 1'b1) pulses++;
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL threshold step %0d: got st/wk/pl/cnt=%b required %b", n, got, exp);
         end
         n++;
      end
      checks++;
      if (pulses !== 1) begin
         failures++;
         $display("FAIL threshold_pulse_count: got %0d required 1", pulses);
      end
   endtask

   task automatic test_zero_threshold();
      logic [CNT_BW+3:0] got, exp;
      int n = 0;
      cfg_hits_i     = 4'd0;
      cfg_cooldown_i = '0;
      plan(1,1,1,0, 2'd2,1,1);
      plan(1,0,0,0, 2'd2,1,0);
      plan(1,0,0,1, 2'd1,0,0);
      while (stim_q.size() > 0) begin
         drive_next();
         @(posedge clk_i); #1;
         exp = exp_q.pop_front();
         got = {state_o, wake_o, wake_pulse_o, wake_count_o};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL zero_threshold step %0d: got st/wk/pl/cnt=%b required %b", n, got, exp);
         end
         n++;
      end
   endtask

   task automatic test_cooldown();
      logic [CNT_BW+3:0] got, exp;
      int n = 0;
      cfg_hits_i     = 4'd1;
      cfg_cooldown_i = 24'd5;
      plan(1,1,1,0, 2'd2,1,1);
      plan(1,0,0,1, 2'd3,0,0);   // cooldown cycle 1
      plan(1,1,1,0, 2'd3,0,0);   // cycles 2..5, positives ignored
      plan(1,1,1,0, 2'd3,0,0);
      plan(1,1,1,0, 2'd3,0,0);
      plan(1,1,1,0, 2'd3,0,0);
      plan(1,0,0,0, 2'd1,0,0);   // back to LISTEN
      plan(1,0,0,1, 2'd1,0,0);   // ack ignored in LISTEN
      plan(0,0,0,0, 2'd0,0,0);
      plan(1,0,0,0, 2'd1,0,0);
      while (stim_q.size() > 0) begin
         drive_next();
         @(posedge clk_i); #1;
         exp = exp_q.pop_front();
         got = {state_o, wake_o, wake_pulse_o, wake_count_o};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL cooldown step %0d: got st/wk/pl/cnt=%b required %b", n, got, exp);
         end
         n++;
      end
   endtask

   task automatic test_enable_drop();
      logic [CNT_BW+3:0] got, exp;
      int n = 0;
      cfg_hits_i     = 4'd3;
      cfg_cooldown_i = '0;
      plan(1,1,1,0, 2'd1,0,0);
      plan(1,1,1,0, 2'd1,0,0);
      plan(1,1,1,0, 2'd2,1,1);
      plan(0,0,0,0, 2'd0,0,0);   // drop in WAKE
      plan(0,1,1,0, 2'd0,0,0);
      plan(1,1,1,0, 2'd1,0,0);   // IDLE: valid not counted
      plan(1,1,1,0, 2'd1,0,0);   // fresh hit 1
      plan(1,1,1,0, 2'd1,0,0);   // hit 2
      plan(1,1,1,0, 2'd2,1,1);   // hit 3
      plan(1,0,0,1, 2'd1,0,0);
      while (stim_q.size() > 0) begin
         drive_next();
         @(posedge clk_i); #1;
         exp = exp_q.pop_front();
         got = {state_o, wake_o, wake_pulse_o, wake_count_o};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL enable_drop step %0d: got st/wk/pl/cnt=%b required %b", n, got, exp);
         end
         n++;
      end
   endtask

   task automatic test_simultaneous();
      logic [CNT_BW+3:0] got, exp;
      int n = 0;
      cfg_hits_i     = 4'd1;
      cfg_cooldown_i = '0;
      plan(1,1,1,1, 2'd2,1,1);   // qualifying valid + ack: wake wins
      plan(1,0,0,1, 2'd1,0,0);
      plan(0,1,1,0, 2'd0,0,0);   // qualifying valid + enable low: IDLE, no pulse
      plan(1,0,0,0, 2'd1,0,0);
      while (stim_q.size() > 0) begin
         drive_next();
         @(posedge clk_i); #1;
         exp = exp_q.pop_front();
         got = {state_o, wake_o, wake_pulse_o, wake_count_o};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL simultaneous step %0d: got st/wk/pl/cnt=%b required %b", n, got, exp);
         end
         n++;
      end
   endtask

   task automatic test_async_reset();
      logic [CNT_BW+3:0] got, exp;
      int n = 0;
      cfg_hits_i     = 4'd1;
      cfg_cooldown_i = 24'd20;
      plan(1,1,1,0, 2'd2,1,1);
      plan(1,0,0,1, 2'd3,0,0);
      plan(1,0,0,0, 2'd3,0,0);
      while (stim_q.size() > 0) begin
         drive_next();
         @(posedge clk_i); #1;
         exp = exp_q.pop_front();
         got = {state_o, wake_o, wake_pulse_o, wake_count_o};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL async_pre step %0d: got st/wk/pl/cnt=%b required %b", n, got, exp);
         end
         n++;
      end
      #3 rst_n_i = 1'b0;
      #1;
      got = {state_o, wake_o, wake_pulse_o, wake_count_o};
      checks++;
      if (got !== '0) begin
         failures++;
         $display("FAIL async_reset_clear: got st/wk/pl/cnt=%b required %b", got, {(CNT_BW+4){1'b0}});
      end
      model_reset();
      #2 rst_n_i = 1'b1;
      cfg_cooldown_i = '0;
      plan(0,0,0,0, 2'd0,0,0);
      plan(1,0,0,0, 2'd1,0,0);
      n = 0;
      while (stim_q.size() > 0) begin
         drive_next();
         @(posedge clk_i); #1;
         exp = exp_q.pop_front();
         got = {state_o, wake_o, wake_pulse_o, wake_count_o};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL async_post step %0d: got st/wk/pl/cnt=%b required %b", n, got, exp);
         end
         n++;
      end
   endtask

   task automatic test_stats();
      logic [CNT_BW+3:0] got, exp;
      logic [CNT_BW-1:0] final_cnt;
      int n = 0;
      cfg_hits_i     = 4'd1;
      cfg_cooldown_i = '0;
      for (int i = 0; i < 4; i++) begin
         plan(1,1,1,0, 2'd2,1,1);
         plan(1,0,0,1, 2'd1,0,0);
      end
      plan(1,0,0,0, 2'd1,0,0);
      while (stim_q.size() > 0) begin
         drive_next();
         @(posedge clk_i); #1;
         exp = exp_q.pop_front();
         got = {state_o, wake_o, wake_pulse_o, wake_count_o};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL stats step %0d: got st/wk/pl/cnt=%b required %b", n, got, exp);
         end
         n++;
      end
`ifdef WAKE_CTL_STATS_EN
      final_cnt = 2'd3;
`else
      final_cnt = 2'd0;
`endif
      checks++;
      if (wake_count_o !== final_cnt) begin
         failures++;
         $display("FAIL stats_final_count: got %0d required %0d", wake_count_o, final_cnt);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_threshold();
      test_zero_threshold();
      test_cooldown();
      test_enable_drop();
      test_simultaneous();
      test_async_reset();
      test_stats();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
